// File: rtl/traffic_signal_vm.sv
// Two-road fixed-time traffic-signal controller (Moore FSM with dwell down-counter).
// Optional macro SIGNAL_HOLD_EN adds a hold input that freezes state, count and lamps.
module traffic_signal_vm #(
  parameter int unsigned GREEN_CYCLES   = 8,
  parameter int unsigned CAUTION_CYCLES = 2,
  parameter int unsigned ALLSTOP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
`ifdef SIGNAL_HOLD_EN
  input  logic hold,
`endif
  output logic Ago,
  output logic Astop,
  output logic Bgo,
  output logic Bstop
);

  localparam int unsigned MAX_GC = (GREEN_CYCLES > CAUTION_CYCLES) ? GREEN_CYCLES : CAUTION_CYCLES;
  localparam int unsigned MAX_D  = (MAX_GC > ALLSTOP_CYCLES) ? MAX_GC : ALLSTOP_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_D) + 1;

  typedef enum logic [2:0] {
    CLR_A  = 3'd0,
    A_GO   = 3'd1,
    A_CAUT = 3'd2,
    CLR_B  = 3'd3,
    B_GO   = 3'd4,
    B_CAUT = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [3:0]    lamps;  // {Ago, Astop, Bgo, Bstop}

  // Successor in the fixed rotation; unused encodings fall back to CLR_A.
  function automatic state_t succ(input state_t s);
    case (s)
      CLR_A:   succ = A_GO;
      A_GO:    succ = A_CAUT;
      A_CAUT:  succ = CLR_B;
      CLR_B:   succ = B_GO;
      B_GO:    succ = B_CAUT;
      default: succ = CLR_A;
    endcase
  endfunction

  function automatic logic legal(input state_t s);
    case (s)
      CLR_A, A_GO, A_CAUT, CLR_B, B_GO, B_CAUT: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] load(input state_t s);
    case (s)
      A_GO, B_GO:     load = CW'(GREEN_CYCLES - 1);
      A_CAUT, B_CAUT: load = CW'(CAUTION_CYCLES - 1);
      default:        load = CW'(ALLSTOP_CYCLES - 1);
    endcase
  endfunction

  // Caution is both lamps of the moving road dark; the other road holds stop.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      A_GO:    decode = 4'b1001;
      A_CAUT:  decode = 4'b0001;
      B_GO:    decode = 4'b0110;
      B_CAUT:  decode = 4'b0100;
      default: decode = 4'b0101;
    endcase
  endfunction

  // Lamps are registered from the same next-state value, so they always match the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLR_A;
      count <= load(CLR_A);
      lamps <= decode(CLR_A);
`ifdef SIGNAL_HOLD_EN
    end else if (!hold) begin
`else
    end else begin
`endif
      if (count == '0 || !legal(state)) begin
        state <= succ(state);
        count <= load(succ(state));
        lamps <= decode(succ(state));
      end else begin
        count <= count - CW'(1);
      end
    end
  end

  assign Ago   = lamps[3];
  assign Astop = lamps[2];
  assign Bgo   = lamps[1];
  assign Bstop = lamps[0];

endmodule

// File: tb/tb_traffic_signal_vm.sv
// Bench for traffic_signal_vm: default and overridden instances compared each cycle
// against a phase-arithmetic reference model, with directed and random resets.
module tb_traffic_signal_vm;

  logic clk;
  logic reset;
  logic a_go0, a_st0, b_go0, b_st0;
  logic a_go1, a_st1, b_go1, b_st1;

  int tests;
  int fails;
  int k;  // non-reset edges since the last reset edge

  traffic_signal_vm dut_def (
    .clk   (clk),
    .reset (reset),
    .Ago   (a_go0),
    .Astop (a_st0),
    .Bgo   (b_go0),
    .Bstop (b_st0)
  );

  traffic_signal_vm #(
    .GREEN_CYCLES   (3),
    .CAUTION_CYCLES (1),
    .ALLSTOP_CYCLES (2)
  ) dut_ovr (
    .clk   (clk),
    .reset (reset),
    .Ago   (a_go1),
    .Astop (a_st1),
    .Bgo   (b_go1),
    .Bstop (b_st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {Ago,Astop,Bgo,Bstop} k cycles after the reset-release cycle began.
  function automatic logic [3:0] model(input int g, input int c, input int a, input int kk);
    int half;
    int t;
    logic road_b;
    half   = g + c + a;
    t      = kk % (2 * half);
    road_b = (t >= half);
    if (road_b) t = t - half;
    if (t < a)          return 4'b0101;
    else if (t < a + g) return road_b ? 4'b0110 : 4'b1001;
    else                return road_b ? 4'b0100 : 4'b0001;
  endfunction

  task automatic check(input string tag);
    logic [3:0] got0, got1, exp0, exp1;
    logic [2:0] bad0, bad1;
    got0 = {a_go0, a_st0, b_go0, b_st0};
    got1 = {a_go1, a_st1, b_go1, b_st1};
    exp0 = model(8, 2, 1, k);
    exp1 = model(3, 1, 2, k);
    bad0 = {a_go0 & b_go0, a_go0 & a_st0, b_go0 & b_st0};
    bad1 = {a_go1 & b_go1, a_go1 & a_st1, b_go1 & b_st1};
    tests++;
    assert (got0 === exp0) else begin
      fails++;
      $error("FAIL %s default k=%0d lamps got %b expected %b", tag, k, got0, exp0);
    end
    tests++;
    assert (got1 === exp1) else begin
      fails++;
      $error("FAIL %s override k=%0d lamps got %b expected %b", tag, k, got1, exp1);
    end
    tests++;
    assert (bad0 === 3'b000 && bad1 === 3'b000) else begin
      fails++;
      $error("FAIL %s safety k=%0d got %b/%b expected 000/000", tag, k, bad0, bad1);
    end
  endtask

  // One clock: drive reset, count the edge in the model, sample on the falling edge.
  task automatic cycle(input logic r, input string tag);
    reset = r;
    @(posedge clk);
    if (r) k = 0;
    else   k++;
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    int hold_left;
    tests = 0;
    fails = 0;
    k     = 0;
    reset = 1'b1;

    // Reset held two cycles, then two full default periods from release.
    cycle(1'b1, "reset0");
    cycle(1'b1, "reset1");
    for (int i = 0; i < 44; i++) cycle(1'b0, "sequence");

    // Abort on cycle 4 of B_GO: all-stop next, then A_GO, no B_CAUT.
    cycle(1'b1, "mid_rst_pre");
    for (int i = 0; i < 15; i++) cycle(1'b0, "to_bgo");
    tests++;
    assert ({a_go0, a_st0, b_go0, b_st0} === 4'b0110) else begin
      fails++;
      $error("FAIL bgo_cycle4 got %b expected 0110", {a_go0, a_st0, b_go0, b_st0});
    end
    cycle(1'b1, "mid_rst");
    for (int i = 0; i < 10; i++) cycle(1'b0, "after_mid_rst");

    // Random resets of 1-3 cycles sprinkled over a long run.
    hold_left = 0;
    for (int i = 0; i < 1000; i++) begin
      if (hold_left == 0 && $urandom_range(0, 39) == 0) hold_left = $urandom_range(1, 3);
      if (hold_left > 0) begin
        hold_left--;
        cycle(1'b1, "rand_rst");
      end else begin
        cycle(1'b0, "rand_run");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
